// File: rtl/axi_lite_master_cmd_if.sv
// AXI4-Lite bus bundle between the command-driven master and an interconnect slave port.
interface axi_lite_master_cmd_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              wvalid;
    logic              wready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi_lite_master_cmd.sv
// Single-outstanding AXI4-Lite master fed by a valid/ready command port, with a
// response timeout that drains the late beat before accepting the next command.
module axi_lite_master_cmd #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic                  aclk,
    input  logic                  areset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [DATA_W/8-1:0]   cmd_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_timeout,
    axi_lite_master_cmd_if.master m_axi
);
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP, DRAIN
    } state_e;

    state_e            state_q, state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              bready_q, bready_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]        rsp_resp_q, rsp_resp_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic              drain_pending_q, drain_pending_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, rsp_hs, timeout_hit, stale_hs;

    assign aw_hs       = awvalid_q && m_axi.awready;
    assign w_hs        = wvalid_q && m_axi.wready;
    assign b_hs        = bready_q && m_axi.bvalid;
    assign ar_hs       = arvalid_q && m_axi.arready;
    assign r_hs        = rready_q && m_axi.rvalid;
    assign rsp_hs      = rsp_valid_q && rsp_ready;
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));
    assign stale_hs    = drain_pending_q && (b_hs || r_hs);

    // Next-state and next-output logic; every register defaults to holding its value.
    always_comb begin
        state_d         = state_q;
        awvalid_d       = awvalid_q;
        wvalid_d        = wvalid_q;
        bready_d        = bready_q;
        arvalid_d       = arvalid_q;
        rready_d        = rready_q;
        awaddr_d        = awaddr_q;
        araddr_d        = araddr_q;
        wdata_d         = wdata_q;
        wstrb_d         = wstrb_q;
        aw_done_d       = aw_done_q;
        w_done_d        = w_done_q;
        rsp_valid_d     = rsp_valid_q;
        rsp_rdata_d     = rsp_rdata_q;
        rsp_resp_d      = rsp_resp_q;
        rsp_timeout_d   = rsp_timeout_q;
        drain_pending_d = drain_pending_q;
        cnt_d           = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_write) begin
                        awaddr_d  = cmd_addr;
                        wdata_d   = cmd_wdata;
                        wstrb_d   = cmd_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = WR_ADDR_DATA;
                    end else begin
                        araddr_d  = cmd_addr;
                        arvalid_d = 1'b1;
                        state_d   = RD_ADDR;
                    end
                end
            end
            WR_ADDR_DATA: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    bready_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (b_hs) begin
                    bready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_resp_d    = m_axi.bresp;
                    rsp_rdata_d   = '0;
                    rsp_timeout_d = 1'b0;
                    state_d       = RESP;
                end else if (timeout_hit) begin
                    rsp_valid_d     = 1'b1;
                    rsp_resp_d      = 2'b10;
                    rsp_rdata_d     = '0;
                    rsp_timeout_d   = 1'b1;
                    drain_pending_d = 1'b1;
                    state_d         = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RD_ADDR: begin
                if (ar_hs) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    cnt_d     = '0;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (r_hs) begin
                    rready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_resp_d    = m_axi.rresp;
                    rsp_rdata_d   = m_axi.rdata;
                    rsp_timeout_d = 1'b0;
                    state_d       = RESP;
                end else if (timeout_hit) begin
                    rsp_valid_d     = 1'b1;
                    rsp_resp_d      = 2'b10;
                    rsp_rdata_d     = '0;
                    rsp_timeout_d   = 1'b1;
                    drain_pending_d = 1'b1;
                    state_d         = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                // A late beat for a timed-out transfer may land while the response waits.
                if (stale_hs) begin
                    bready_d        = 1'b0;
                    rready_d        = 1'b0;
                    drain_pending_d = 1'b0;
                end
                if (rsp_hs) begin
                    rsp_valid_d = 1'b0;
                    state_d     = (drain_pending_q && !stale_hs) ? DRAIN : IDLE;
                end
            end
            DRAIN: begin
                if (b_hs || r_hs) begin
                    bready_d        = 1'b0;
                    rready_d        = 1'b0;
                    drain_pending_d = 1'b0;
                    state_d         = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        cmd_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_q         <= IDLE;
            cmd_ready_q     <= 1'b1;
            awvalid_q       <= 1'b0;
            wvalid_q        <= 1'b0;
            bready_q        <= 1'b0;
            arvalid_q       <= 1'b0;
            rready_q        <= 1'b0;
            awaddr_q        <= '0;
            araddr_q        <= '0;
            wdata_q         <= '0;
            wstrb_q         <= '0;
            aw_done_q       <= 1'b0;
            w_done_q        <= 1'b0;
            rsp_valid_q     <= 1'b0;
            rsp_rdata_q     <= '0;
            rsp_resp_q      <= 2'b00;
            rsp_timeout_q   <= 1'b0;
            drain_pending_q <= 1'b0;
            cnt_q           <= '0;
        end else begin
            state_q         <= state_d;
            cmd_ready_q     <= cmd_ready_d;
            awvalid_q       <= awvalid_d;
            wvalid_q        <= wvalid_d;
            bready_q        <= bready_d;
            arvalid_q       <= arvalid_d;
            rready_q        <= rready_d;
            awaddr_q        <= awaddr_d;
            araddr_q        <= araddr_d;
            wdata_q         <= wdata_d;
            wstrb_q         <= wstrb_d;
            aw_done_q       <= aw_done_d;
            w_done_q        <= w_done_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_rdata_q     <= rsp_rdata_d;
            rsp_resp_q      <= rsp_resp_d;
            rsp_timeout_q   <= rsp_timeout_d;
            drain_pending_q <= drain_pending_d;
            cnt_q           <= cnt_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign rsp_timeout   = rsp_timeout_q;
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.awaddr  = awaddr_q;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = wstrb_q;
    assign m_axi.bready  = bready_q;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.araddr  = araddr_q;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.rready  = rready_q;
endmodule

// File: tb/tb_axi_lite_master_cmd.sv
// Directed bench for axi_lite_master_cmd: write/read paths, handshake orderings,
// response backpressure, timeout with drain, async reset and back-to-back commands.
module tb_axi_lite_master_cmd;
    logic        aclk;
    logic        areset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;

    int checks = 0;
    int errors = 0;

    axi_lite_master_cmd_if #(.ADDR_W(32), .DATA_W(32)) axi ();

    axi_lite_master_cmd #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .aclk        (aclk),
        .areset_n    (areset_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_wstrb   (cmd_wstrb),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_resp    (rsp_resp),
        .rsp_timeout (rsp_timeout),
        .m_axi       (axi)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        areset_n    = 1'b1;
        cmd_valid   = 1'b0;
        cmd_write   = 1'b0;
        cmd_addr    = '0;
        cmd_wdata   = '0;
        cmd_wstrb   = '0;
        rsp_ready   = 1'b0;
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        axi.bresp   = 2'b00;
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        axi.rdata   = '0;
        axi.rresp   = 2'b00;

        // Reset state
        #2 areset_n = 1'b0;
        #1;
        chk("rst_cmd_ready", 64'(cmd_ready), 64'h1);
        chk("rst_awvalid", 64'(axi.awvalid), 64'h0);
        chk("rst_wvalid", 64'(axi.wvalid), 64'h0);
        chk("rst_arvalid", 64'(axi.arvalid), 64'h0);
        chk("rst_bready", 64'(axi.bready), 64'h0);
        chk("rst_rready", 64'(axi.rready), 64'h0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rst_awaddr", 64'(axi.awaddr), 64'h0);
        chk("rst_awprot", 64'(axi.awprot), 64'h0);
        tick();
        tick();
        areset_n = 1'b1;
        tick();

        // Write, AW and W accepted in the same cycle, OKAY response
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h4;
        cmd_wdata = 32'hDEADBEEF; cmd_wstrb = 4'hF;
        axi.awready = 1'b1; axi.wready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("w1_awvalid", 64'(axi.awvalid), 64'h1);
        chk("w1_wvalid", 64'(axi.wvalid), 64'h1);
        chk("w1_awaddr", 64'(axi.awaddr), 64'h4);
        chk("w1_wdata", 64'(axi.wdata), 64'hDEADBEEF);
        chk("w1_wstrb", 64'(axi.wstrb), 64'hF);
        chk("w1_cmd_ready", 64'(cmd_ready), 64'h0);
        tick();
        chk("w1_awvalid_drop", 64'(axi.awvalid), 64'h0);
        chk("w1_wvalid_drop", 64'(axi.wvalid), 64'h0);
        chk("w1_bready", 64'(axi.bready), 64'h1);
        axi.awready = 1'b0; axi.wready = 1'b0;
        axi.bvalid = 1'b1; axi.bresp = 2'b00;
        tick();
        axi.bvalid = 1'b0;
        chk("w1_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("w1_rsp_resp", 64'(rsp_resp), 64'h0);
        chk("w1_rsp_rdata", 64'(rsp_rdata), 64'h0);
        chk("w1_rsp_timeout", 64'(rsp_timeout), 64'h0);
        chk("w1_bready_drop", 64'(axi.bready), 64'h0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("w1_rsp_done", 64'(rsp_valid), 64'h0);
        chk("w1_cmd_ready_back", 64'(cmd_ready), 64'h1);

        // Write, W accepted first, AW accepted three cycles later, SLVERR response
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h10;
        cmd_wdata = 32'hA5A5A5A5; cmd_wstrb = 4'h3;
        tick();
        cmd_valid = 1'b0;
        chk("w2_c0_awvalid", 64'(axi.awvalid), 64'h1);
        chk("w2_c0_wvalid", 64'(axi.wvalid), 64'h1);
        tick();
        chk("w2_c1_wvalid", 64'(axi.wvalid), 64'h1);
        axi.wready = 1'b1;
        tick();
        axi.wready = 1'b0;
        chk("w2_c2_wvalid_drop", 64'(axi.wvalid), 64'h0);
        chk("w2_c2_awvalid", 64'(axi.awvalid), 64'h1);
        chk("w2_c2_awaddr", 64'(axi.awaddr), 64'h10);
        chk("w2_c2_bready", 64'(axi.bready), 64'h0);
        tick();
        chk("w2_c3_awvalid", 64'(axi.awvalid), 64'h1);
        chk("w2_c3_awaddr", 64'(axi.awaddr), 64'h10);
        tick();
        chk("w2_c4_awvalid", 64'(axi.awvalid), 64'h1);
        axi.awready = 1'b1;
        tick();
        axi.awready = 1'b0;
        chk("w2_awvalid_drop", 64'(axi.awvalid), 64'h0);
        chk("w2_bready", 64'(axi.bready), 64'h1);
        axi.bvalid = 1'b1; axi.bresp = 2'b10;
        tick();
        axi.bvalid = 1'b0;
        chk("w2_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("w2_rsp_resp", 64'(rsp_resp), 64'h2);
        chk("w2_rsp_timeout", 64'(rsp_timeout), 64'h0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("w2_cmd_ready_back", 64'(cmd_ready), 64'h1);

        // Read with delayed arready and response backpressure
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h8;
        tick();
        cmd_valid = 1'b0;
        chk("r1_arvalid", 64'(axi.arvalid), 64'h1);
        chk("r1_araddr", 64'(axi.araddr), 64'h8);
        chk("r1_arprot", 64'(axi.arprot), 64'h0);
        tick();
        chk("r1_arvalid_hold", 64'(axi.arvalid), 64'h1);
        axi.arready = 1'b1;
        tick();
        axi.arready = 1'b0;
        chk("r1_arvalid_drop", 64'(axi.arvalid), 64'h0);
        chk("r1_rready", 64'(axi.rready), 64'h1);
        axi.rvalid = 1'b1; axi.rdata = 32'h12345678; axi.rresp = 2'b00;
        tick();
        axi.rvalid = 1'b0; axi.rdata = 32'h0;
        chk("r1_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("r1_rsp_rdata", 64'(rsp_rdata), 64'h12345678);
        chk("r1_rsp_resp", 64'(rsp_resp), 64'h0);
        chk("r1_rready_drop", 64'(axi.rready), 64'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("r1_hold_valid", 64'(rsp_valid), 64'h1);
            chk("r1_hold_rdata", 64'(rsp_rdata), 64'h12345678);
            chk("r1_hold_cmd_ready", 64'(cmd_ready), 64'h0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("r1_rsp_done", 64'(rsp_valid), 64'h0);
        chk("r1_cmd_ready_back", 64'(cmd_ready), 64'h1);

        // Read timeout after 8 cycles in RD_DATA, then a late beat is drained
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h20;
        axi.arready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        axi.arready = 1'b0;
        chk("to_rready", 64'(axi.rready), 64'h1);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("to_wait_rsp_valid", 64'(rsp_valid), 64'h0);
        end
        tick();
        chk("to_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("to_rsp_timeout", 64'(rsp_timeout), 64'h1);
        chk("to_rsp_resp", 64'(rsp_resp), 64'h2);
        chk("to_rsp_rdata", 64'(rsp_rdata), 64'h0);
        chk("to_rready_kept", 64'(axi.rready), 64'h1);
        chk("to_cmd_ready", 64'(cmd_ready), 64'h0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("to_drain_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("to_drain_cmd_ready", 64'(cmd_ready), 64'h0);
        chk("to_drain_rready", 64'(axi.rready), 64'h1);
        tick();
        tick();
        chk("to_drain_wait_cmd_ready", 64'(cmd_ready), 64'h0);
        axi.rvalid = 1'b1; axi.rdata = 32'h00000BAD; axi.rresp = 2'b00;
        tick();
        axi.rvalid = 1'b0;
        chk("to_drained_cmd_ready", 64'(cmd_ready), 64'h1);
        chk("to_drained_rready", 64'(axi.rready), 64'h0);
        chk("to_drained_rsp_valid", 64'(rsp_valid), 64'h0);

        // Asynchronous reset in the middle of a write address/data phase
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h50;
        cmd_wdata = 32'h11112222; cmd_wstrb = 4'hF;
        tick();
        cmd_valid = 1'b0;
        chk("ar_pre_awvalid", 64'(axi.awvalid), 64'h1);
        #2 areset_n = 1'b0;
        #1;
        chk("ar_awvalid", 64'(axi.awvalid), 64'h0);
        chk("ar_wvalid", 64'(axi.wvalid), 64'h0);
        chk("ar_awaddr", 64'(axi.awaddr), 64'h0);
        chk("ar_cmd_ready", 64'(cmd_ready), 64'h1);
        chk("ar_rsp_valid", 64'(rsp_valid), 64'h0);
        #1 areset_n = 1'b1;
        tick();
        chk("ar_no_rsp", 64'(rsp_valid), 64'h0);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h30;
        axi.arready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("ar_rd_arvalid", 64'(axi.arvalid), 64'h1);
        chk("ar_rd_araddr", 64'(axi.araddr), 64'h30);
        tick();
        axi.arready = 1'b0;
        chk("ar_rd_rready", 64'(axi.rready), 64'h1);
        axi.rvalid = 1'b1; axi.rdata = 32'hCAFEF00D; axi.rresp = 2'b01;
        tick();
        axi.rvalid = 1'b0;
        chk("ar_rd_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("ar_rd_rsp_rdata", 64'(rsp_rdata), 64'hCAFEF00D);
        chk("ar_rd_rsp_resp", 64'(rsp_resp), 64'h1);
        chk("ar_rd_rsp_timeout", 64'(rsp_timeout), 64'h0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("ar_rd_cmd_ready", 64'(cmd_ready), 64'h1);

        // Back-to-back writes with cmd_valid held and the slave always ready
        axi.awready = 1'b1; axi.wready = 1'b1;
        axi.bvalid = 1'b1; axi.bresp = 2'b00;
        rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h40;
        cmd_wdata = 32'h0000AAAA; cmd_wstrb = 4'h1;
        tick();
        chk("bb_awvalid", 64'(axi.awvalid), 64'h1);
        tick();
        chk("bb_bready", 64'(axi.bready), 64'h1);
        tick();
        chk("bb_rsp_valid", 64'(rsp_valid), 64'h1);
        tick();
        chk("bb_rsp_done", 64'(rsp_valid), 64'h0);
        chk("bb_cmd_ready", 64'(cmd_ready), 64'h1);
        chk("bb_awvalid_idle", 64'(axi.awvalid), 64'h0);
        cmd_addr = 32'h44; cmd_wdata = 32'h0000BBBB;
        tick();
        cmd_valid = 1'b0;
        chk("bb2_awvalid", 64'(axi.awvalid), 64'h1);
        chk("bb2_awaddr", 64'(axi.awaddr), 64'h44);
        chk("bb2_wdata", 64'(axi.wdata), 64'hBBBB);
        chk("bb2_cmd_ready", 64'(cmd_ready), 64'h0);
        tick();
        tick();
        chk("bb2_rsp_valid", 64'(rsp_valid), 64'h1);
        tick();
        chk("bb2_cmd_ready_back", 64'(cmd_ready), 64'h1);
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0;
        rsp_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
